// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit, 4-register CPU: register index/value types and
// the write-back entry carried from execute into the write-back FIFO.
package cpu_pkg;

    localparam int NREGS = 4;
    localparam int REG_W = 8;
    localparam int OPC_W = 4;

    typedef logic [1:0] reg_idx_t;
    typedef logic [7:0] reg_val_t;

    typedef struct packed {
        reg_idx_t idx;
        reg_val_t val;
    } wb_entry_t;

    function automatic logic [NREGS-1:0] idx_onehot(input reg_idx_t idx);
        logic [NREGS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Result queue between execute and register-file write-back. Entries are
// exported oldest-first (slot 0 = head) together with a matching valid mask.
import cpu_pkg::*;

module wb_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  wb_entry_t                   din,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output wb_entry_t [DEPTH-1:0]       entries,
    output logic      [DEPTH-1:0]       valid
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem;
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           count;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Rotate storage so consumers see entries in age order, head first.
    always_comb begin
        logic [AW-1:0] slot;
        entries = '0;
        valid   = '0;
        slot    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot       = rd_ptr[AW-1:0] + AW'(k);
            entries[k] = mem[slot];
            valid[k]   = ((AW+1)'(k) < count);
        end
    end

endmodule

// File: rtl/cpu_wb.sv
// Write-back stage: queues execute results and retires one per enabled cycle
// into the register file. Define WB_BYPASS_EN for a write-through regs view.
import cpu_pkg::*;

module cpu_wb #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          res_valid,
    output logic                          res_ready,
    input  reg_idx_t                      res_dst_idx,
    input  reg_val_t                      res_val,
    input  logic                          wb_en,
    output reg_val_t [0:NREGS-1]          regs,
    output logic     [NREGS-1:0]          pending,
    output logic     [CNT_W-1:0]          retire_cnt
);

    wb_entry_t [DEPTH-1:0] entries;
    logic      [DEPTH-1:0] valid;
    logic                  full;
    logic                  empty;
    logic                  do_push;
    logic                  do_pop;
    wb_entry_t             din;
    reg_val_t [0:NREGS-1]  rf;

    // Ready looks only at occupancy, so there is no path from inputs to ready.
    assign res_ready = !full && rst_n;
    assign do_push   = res_valid && res_ready;
    assign do_pop    = wb_en && !empty;

    assign din.idx = res_dst_idx;
    assign din.val = res_val;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (do_push),
        .din     (din),
        .pop     (do_pop),
        .full    (full),
        .empty   (empty),
        .entries (entries),
        .valid   (valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf         <= '0;
            retire_cnt <= '0;
        end else if (do_pop) begin
            rf[entries[0].idx] <= entries[0].val;
            retire_cnt         <= retire_cnt + 1'b1;
        end
    end

    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[k]) begin
                pending = pending | idx_onehot(entries[k].idx);
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the youngest queued write to a register wins.
    always_comb begin
        regs = rf;
        for (int k = 0; k < DEPTH; k++) begin
            for (int r = 0; r < NREGS; r++) begin
                if (valid[k] && (entries[k].idx == reg_idx_t'(r))) begin
                    regs[r] = entries[k].val;
                end
            end
        end
    end
`else
    assign regs = rf;
`endif

endmodule

// File: tb/tb_cpu_wb.sv
// Scoreboard bench for cpu_wb: directed pushes queue expected retirements,
// a negedge monitor pops and checks them whenever retire_cnt advances.
import cpu_pkg::*;

module tb_cpu_wb;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 res_valid = 1'b0;
    logic                 res_ready;
    reg_idx_t             res_dst_idx = '0;
    reg_val_t             res_val = '0;
    logic                 wb_en = 1'b0;
    reg_val_t [0:NREGS-1] regs;
    logic [NREGS-1:0]     pending;
    logic [CNT_W-1:0]     retire_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;

    wb_entry_t        exp_q[$];
    reg_val_t         model_regs [NREGS];
    logic [CNT_W-1:0] model_cnt = '0;
    logic [CNT_W-1:0] last_cnt  = '0;
    wb_entry_t        mon_ent;

    always #5 clk = ~clk;

    cpu_wb #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_dst_idx (res_dst_idx),
        .res_val     (res_val),
        .wb_en       (wb_en),
        .regs        (regs),
        .pending     (pending),
        .retire_cnt  (retire_cnt)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected decode-side view of register r, given retired state and queue.
    function automatic reg_val_t view_of(input int r);
        reg_val_t v;
        v = model_regs[r];
        if (BYPASS) begin
            foreach (exp_q[k]) begin
                if (exp_q[k].idx == reg_idx_t'(r)) v = exp_q[k].val;
            end
        end
        return v;
    endfunction

    // One clock of stimulus; returns just after the following negedge.
    task automatic apply_stimulus(input logic v, input reg_idx_t idx, input reg_val_t val, input logic en);
        logic      hs;
        wb_entry_t ent;
        res_valid   = v;
        res_dst_idx = idx;
        res_val     = val;
        wb_en       = en;
        #1;
        hs = v && res_ready;
        @(posedge clk);
        if (hs) begin
            ent.idx = idx;
            ent.val = val;
            exp_q.push_back(ent);
        end
        @(negedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < NREGS; r++) check_output({tag, "_reg"}, regs[r], 8'h00);
        check_output({tag, "_pending"}, pending, 4'b0000);
        check_output({tag, "_cnt"}, retire_cnt, 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_cnt = '0;
        end else if (retire_cnt !== last_cnt) begin
            last_cnt = retire_cnt;
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL sb_spurious_retire: got retire_cnt %0h, expected no retirement", retire_cnt);
            end else begin
                mon_ent = exp_q.pop_front();
                model_regs[mon_ent.idx] = mon_ent.val;
                model_cnt = model_cnt + 1'b1;
                check_output("sb_cnt", retire_cnt, model_cnt);
                check_output("sb_reg", regs[mon_ent.idx], view_of(int'(mon_ent.idx)));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        foreach (model_regs[r]) model_regs[r] = '0;

        @(negedge clk);
        #2;
        check_all_zero("reset");
        check_output("reset_ready", res_ready, 1'b0);
        rst_n = 1'b1;
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1);
        check_all_zero("idle");
        check_output("idle_ready", res_ready, 1'b1);

        apply_stimulus(1'b1, 2'd2, 8'hA5, 1'b1);
        check_output("t1_pending", pending, 4'b0100);
        check_output("t1_reg2_queued", regs[2], BYPASS ? 8'hA5 : 8'h00);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1);
        check_output("t1_reg2", regs[2], 8'hA5);
        check_output("t1_pending_clr", pending, 4'b0000);
        check_output("t1_cnt", retire_cnt, 1);

        apply_stimulus(1'b1, 2'd1, 8'h11, 1'b0);
        check_output("t2_pending1", pending, 4'b0010);
        check_output("t2_ready1", res_ready, 1'b1);
        apply_stimulus(1'b1, 2'd3, 8'h33, 1'b0);
        check_output("t2_full_ready", res_ready, 1'b0);
        check_output("t2_pending2", pending, 4'b1010);
        check_output("t2_reg1", regs[1], BYPASS ? 8'h11 : 8'h00);
        check_output("t2_reg3", regs[3], BYPASS ? 8'h33 : 8'h00);
        check_output("t2_cnt", retire_cnt, 1);

        apply_stimulus(1'b1, 2'd0, 8'h77, 1'b1);
        check_output("t3_reg1", regs[1], 8'h11);
        check_output("t3_cnt", retire_cnt, 2);
        check_output("t3_ready", res_ready, 1'b1);
        check_output("t3_pending", pending, 4'b1000);
        check_output("t3_reg3_queued", regs[3], BYPASS ? 8'h33 : 8'h00);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1);
        check_output("t3_reg3", regs[3], 8'h33);
        check_output("t3_cnt2", retire_cnt, 3);
        check_output("t3_pending_clr", pending, 4'b0000);

        apply_stimulus(1'b1, 2'd0, 8'h01, 1'b1);
        check_output("t4_pending", pending, 4'b0001);
        check_output("t4_reg0_a", regs[0], BYPASS ? 8'h01 : 8'h00);
        apply_stimulus(1'b1, 2'd0, 8'h02, 1'b1);
        check_output("t4_reg0_b", regs[0], BYPASS ? 8'h02 : 8'h01);
        check_output("t4_cnt_b", retire_cnt, 4);
        check_output("t4_pending_b", pending, 4'b0001);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1);
        check_output("t4_reg0_c", regs[0], 8'h02);
        check_output("t4_cnt_c", retire_cnt, 5);

        apply_stimulus(1'b1, 2'd0, 8'h0A, 1'b0);
        apply_stimulus(1'b1, 2'd0, 8'h0B, 1'b0);
        check_output("t5_reg0_youngest", regs[0], BYPASS ? 8'h0B : 8'h02);
        check_output("t5_pending", pending, 4'b0001);
        check_output("t5_ready", res_ready, 1'b0);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1);
        check_output("t5_reg0_a", regs[0], BYPASS ? 8'h0B : 8'h0A);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1);
        check_output("t5_reg0_b", regs[0], 8'h0B);
        check_output("t5_cnt", retire_cnt, 7);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1);
        check_output("empty_cnt_hold", retire_cnt, 7);
        check_output("empty_reg0_hold", regs[0], 8'h0B);

        apply_stimulus(1'b1, 2'd1, 8'hC1, 1'b0);
        apply_stimulus(1'b1, 2'd2, 8'hC2, 1'b0);
        check_output("t6_pending", pending, 4'b0110);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        check_output("async_rst_ready", res_ready, 1'b0);
        exp_q.delete();
        foreach (model_regs[r]) model_regs[r] = '0;
        model_cnt = '0;
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1);
        rst_n = 1'b1;
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1);
        check_all_zero("post_rst");
        check_output("post_rst_ready", res_ready, 1'b1);

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(1'b1, reg_idx_t'(i % 4), reg_val_t'(i * 3 + 1), 1'b1);
        end
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1);
        check_output("wrap_cnt", retire_cnt, 1);
        check_output("wrap_reg0", regs[0], 8'h31);
        check_output("wrap_reg1", regs[1], 8'h28);
        check_output("wrap_reg2", regs[2], 8'h2B);
        check_output("wrap_reg3", regs[3], 8'h2E);
        check_output("wrap_pending", pending, 4'b0000);

        check_output("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
